// File: rtl/turn_ctrl.sv
`default_nettype none
// ============================================================================
// turn_ctrl : tic-tac-toe move sequencer with legality, win and draw detection
// Rev 1.0
// ============================================================================
module turn_ctrl #(
  parameter int N      = 3,
  parameter int CELL_W = 2,
  parameter int IDX_W  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  new_game,
  input  logic                  x_req,
  input  logic [IDX_W-1:0]      x_loc,
  input  logic                  o_req,
  input  logic [IDX_W-1:0]      o_loc,
  input  logic [N*N*CELL_W-1:0] board_in,
  output logic [IDX_W-1:0]      upd_loc,
  output logic [CELL_W-1:0]     upd_val,
  output logic                  board_clr,
  output logic                  x_ack,
  output logic                  x_nak,
  output logic                  o_ack,
  output logic                  o_nak,
  output logic                  turn,
  output logic                  game_over,
  output logic [1:0]            winner,
  output logic [IDX_W-1:0]      move_cnt
);

  localparam int                c_cells    = N * N;
  localparam logic [IDX_W-1:0]  c_idle_loc = IDX_W'(c_cells);
  localparam logic [CELL_W-1:0] c_mark_x   = CELL_W'(1);
  localparam logic [CELL_W-1:0] c_mark_o   = CELL_W'(2);
  localparam logic [1:0]        c_draw     = 2'd3;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                turn_q, turn_d;
  logic                game_over_q, game_over_d;
  logic [1:0]          winner_q, winner_d;
  logic [IDX_W-1:0]    move_cnt_q, move_cnt_d;
  logic [IDX_W-1:0]    upd_loc_q, upd_loc_d;
  logic [CELL_W-1:0]   upd_val_q, upd_val_d;
  logic                board_clr_q, board_clr_d;
  logic                x_ack_q, x_ack_d, x_nak_q, x_nak_d;
  logic                o_ack_q, o_ack_d, o_nak_q, o_nak_d;

  logic [CELL_W-1:0]   cells [c_cells];
  logic [CELL_W-1:0]   mark;
  logic                cur_req, oth_req, cur_blank, cur_legal, win;
  logic [IDX_W-1:0]    cur_loc;

  always_comb begin
    for (int i = 0; i < c_cells; i++) begin
      cells[i] = board_in[i*CELL_W +: CELL_W];
    end
  end

  // The mover is always the current-turn player; turn only flips on leaving CHECK.
  always_comb begin
    mark      = turn_q ? c_mark_o : c_mark_x;
    cur_req   = turn_q ? o_req : x_req;
    cur_loc   = turn_q ? o_loc : x_loc;
    oth_req   = turn_q ? x_req : o_req;
    cur_blank = 1'b0;
    for (int i = 0; i < c_cells; i++) begin
      if (cur_loc == IDX_W'(i)) begin
        cur_blank = (cells[i] == '0);
      end
    end
    cur_legal = (cur_loc < c_idle_loc) && cur_blank;
  end

  always_comb begin
    logic row_ok, col_ok, d0_ok, d1_ok;
    win   = 1'b0;
    d0_ok = 1'b1;
    d1_ok = 1'b1;
    for (int r = 0; r < N; r++) begin
      row_ok = 1'b1;
      col_ok = 1'b1;
      for (int c = 0; c < N; c++) begin
        row_ok = row_ok & (cells[N*r + c] == mark);
        col_ok = col_ok & (cells[N*c + r] == mark);
      end
      win   = win | row_ok | col_ok;
      d0_ok = d0_ok & (cells[N*r + r] == mark);
      d1_ok = d1_ok & (cells[N*r + (N-1-r)] == mark);
    end
    win = win | d0_ok | d1_ok;
  end

  always_comb begin
    state_d     = state_q;
    turn_d      = turn_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    move_cnt_d  = move_cnt_q;
    upd_loc_d   = c_idle_loc;
    upd_val_d   = '0;
    board_clr_d = 1'b0;
    x_ack_d     = 1'b0;
    x_nak_d     = 1'b0;
    o_ack_d     = 1'b0;
    o_nak_d     = 1'b0;

    case (state_q)
      // CLEAR lasts two cycles after reset (strobe not yet raised) and one
      // cycle on new_game entry, where the strobe is raised together with it.
      S_CLEAR: begin
        turn_d      = 1'b0;
        winner_d    = 2'd0;
        move_cnt_d  = '0;
        game_over_d = 1'b0;
        if (board_clr_q) begin
          state_d = S_IDLE;
        end else begin
          board_clr_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (turn_q) x_nak_d = x_req;
        else        o_nak_d = o_req;
        if (cur_req) begin
          if (cur_legal) begin
            upd_loc_d = cur_loc;
            upd_val_d = mark;
            state_d   = S_WRITE;
          end else if (turn_q) begin
            o_nak_d = 1'b1;
          end else begin
            x_nak_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        move_cnt_d = move_cnt_q + 1'b1;
        x_ack_d    = ~turn_q;
        o_ack_d    = turn_q;
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        if (win) begin
          winner_d    = 2'(mark);
          game_over_d = 1'b1;
          state_d     = S_DONE;
        end else if (move_cnt_q == c_idle_loc) begin
          winner_d    = c_draw;
          game_over_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          turn_d  = ~turn_q;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        x_nak_d = x_req;
        o_nak_d = o_req;
      end
      default: state_d = S_CLEAR;
    endcase

    if (new_game && (state_q != S_CLEAR)) begin
      state_d     = S_CLEAR;
      board_clr_d = 1'b1;
      turn_d      = 1'b0;
      winner_d    = 2'd0;
      move_cnt_d  = '0;
      game_over_d = 1'b0;
      upd_loc_d   = c_idle_loc;
      upd_val_d   = '0;
      x_ack_d     = 1'b0;
      x_nak_d     = 1'b0;
      o_ack_d     = 1'b0;
      o_nak_d     = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      turn_q      <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 2'd0;
      move_cnt_q  <= '0;
      upd_loc_q   <= c_idle_loc;
      upd_val_q   <= '0;
      board_clr_q <= 1'b0;
      x_ack_q     <= 1'b0;
      x_nak_q     <= 1'b0;
      o_ack_q     <= 1'b0;
      o_nak_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      turn_q      <= turn_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      move_cnt_q  <= move_cnt_d;
      upd_loc_q   <= upd_loc_d;
      upd_val_q   <= upd_val_d;
      board_clr_q <= board_clr_d;
      x_ack_q     <= x_ack_d;
      x_nak_q     <= x_nak_d;
      o_ack_q     <= o_ack_d;
      o_nak_q     <= o_nak_d;
    end
  end

  assign upd_loc   = upd_loc_q;
  assign upd_val   = upd_val_q;
  assign board_clr = board_clr_q;
  assign x_ack     = x_ack_q;
  assign x_nak     = x_nak_q;
  assign o_ack     = o_ack_q;
  assign o_nak     = o_nak_q;
  assign turn      = turn_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;
  assign move_cnt  = move_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_turn_ctrl.sv
`default_nettype none
// ============================================================================
// tb_turn_ctrl : scoreboard bench for turn_ctrl with a game-level reference model
// Rev 1.0
// ============================================================================
module tb_turn_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        new_game = 1'b0;
  logic        x_req = 1'b0, o_req = 1'b0;
  logic [3:0]  x_loc = '0, o_loc = '0;
  logic [17:0] board_in;
  logic [3:0]  upd_loc;
  logic [1:0]  upd_val;
  logic        board_clr, x_ack, x_nak, o_ack, o_nak, turn, game_over;
  logic [1:0]  winner;
  logic [3:0]  move_cnt;

  turn_ctrl dut (
    .clock(clock), .reset(reset), .new_game(new_game),
    .x_req(x_req), .x_loc(x_loc), .o_req(o_req), .o_loc(o_loc),
    .board_in(board_in), .upd_loc(upd_loc), .upd_val(upd_val),
    .board_clr(board_clr), .x_ack(x_ack), .x_nak(x_nak),
    .o_ack(o_ack), .o_nak(o_nak), .turn(turn), .game_over(game_over),
    .winner(winner), .move_cnt(move_cnt)
  );

  always #5 clock = ~clock;

  // Board store emulation
  logic [1:0] store [9];
  always_ff @(posedge clock) begin
    if (reset || board_clr) begin
      for (int i = 0; i < 9; i++) store[i] <= 2'd0;
    end else if (upd_loc < 4'd9) begin
      store[upd_loc] <= upd_val;
    end
  end
  always_comb begin
    board_in = '0;
    for (int i = 0; i < 9; i++) board_in[i*2 +: 2] = store[i];
  end

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: game state at move granularity
  int bm [9];
  int m_turn, m_cnt, m_win, m_over;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic bit has_line(input int mk);
    for (int l = 0; l < 8; l++)
      if (bm[lines[l][0]] == mk && bm[lines[l][1]] == mk && bm[lines[l][2]] == mk) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) bm[i] = 0;
    m_turn = 0; m_cnt = 0; m_win = 0; m_over = 0;
  endtask

  // Scoreboard queues: per-player responses (1 = ack, 0 = nak) and board writes
  int qx[$], qo[$], wq[$];
  int clr_cnt = 0, clr_exp = 0;
  int wr_cyc = -1, ack_cyc = -1, nak_cyc = -1;

  always @(negedge clock) begin
    if (!reset) begin
      if (board_clr) clr_cnt++;
      if (upd_loc != 4'd9) begin
        wr_cyc = cyc;
        if (wq.size() == 0) chk("unexpected_write", upd_loc, 9);
        else chk("write_loc_val", {upd_loc, upd_val}, wq.pop_front());
      end
      if (x_ack || x_nak) begin
        if (x_ack) ack_cyc = cyc; else nak_cyc = cyc;
        if (qx.size() == 0) chk("unexpected_x_resp", {x_ack, x_nak}, 0);
        else chk("x_resp(ack=1)", {x_ack, x_nak}, qx.pop_front() ? 2 : 1);
      end
      if (o_ack || o_nak) begin
        if (o_ack) ack_cyc = cyc; else nak_cyc = cyc;
        if (qo.size() == 0) chk("unexpected_o_resp", {o_ack, o_nak}, 0);
        else chk("o_resp(ack=1)", {o_ack, o_nak}, qo.pop_front() ? 2 : 1);
      end
    end
  end

  function automatic int evaluate(input int p, input int loc);
    if (m_over != 0 || p != m_turn || loc > 8) return 0;
    return (bm[loc] == 0) ? 1 : 0;
  endfunction

  task automatic push_resp(input int p, input int r);
    if (p == 0) qx.push_back(r); else qo.push_back(r);
  endtask

  task automatic apply_move(input int loc);
    int mk;
    mk = m_turn + 1;
    wq.push_back(loc * 4 + mk);
    bm[loc] = mk;
    m_cnt++;
    if (has_line(mk)) begin m_win = mk; m_over = 1; end
    else if (m_cnt == 9) begin m_win = 3; m_over = 1; end
    else m_turn ^= 1;
  endtask

  task automatic check_status();
    chk("turn", turn, m_turn);
    chk("winner", winner, m_win);
    chk("game_over", game_over, m_over);
    chk("move_cnt", move_cnt, m_cnt);
  endtask

  // Requests for both players (en bits); current-turn player evaluated, other nak'd.
  task automatic issue(input bit xen, input int xl, input bit oen, input int ol);
    int p, r, t, l;
    p = m_turn;
    l = (p == 0) ? xl : ol;
    r = 0;
    if (m_over != 0) begin
      if (xen) push_resp(0, 0);
      if (oen) push_resp(1, 0);
    end else begin
      if (p == 0 && oen) push_resp(1, 0);
      if (p == 1 && xen) push_resp(0, 0);
      if ((p == 0 && xen) || (p == 1 && oen)) begin
        r = evaluate(p, l);
        push_resp(p, r);
        if (r != 0) apply_move(l);
      end
    end
    @(posedge clock); #1;
    x_req = xen; x_loc = 4'(xl); o_req = oen; o_loc = 4'(ol);
    t = cyc + 1;
    @(posedge clock); #1;
    x_req = 1'b0; o_req = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    if (r != 0) begin
      chk("write_latency", wr_cyc, t);
      chk("ack_latency", ack_cyc, t + 1);
    end else begin
      chk("nak_latency", nak_cyc, t);
    end
    check_status();
  endtask

  task automatic move(input int p, input int loc);
    if (p == 0) issue(1'b1, loc, 1'b0, 0);
    else        issue(1'b0, 0, 1'b1, loc);
  endtask

  task automatic start_new_game();
    @(posedge clock); #1;
    new_game = 1'b1;
    @(posedge clock); #1;
    new_game = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    model_reset();
    clr_exp++;
    chk("board_clr_count", clr_cnt, clr_exp);
    check_status();
  endtask

  // Legal X move on a fresh board, abandoned by new_game while in WRITE.
  task automatic abort_in_write(input int loc);
    wq.push_back(loc * 4 + 1);
    @(posedge clock); #1;
    x_req = 1'b1; x_loc = 4'(loc);
    @(posedge clock); #1;
    x_req = 1'b0; new_game = 1'b1;
    @(negedge clock);
    chk("abort_write_loc", upd_loc, loc);
    @(posedge clock); #1;
    new_game = 1'b0;
    @(negedge clock);
    chk("abort_board_clr", board_clr, 1);
    chk("abort_move_cnt", move_cnt, 0);
    chk("abort_turn", turn, 0);
    repeat (4) @(posedge clock);
    #1;
    model_reset();
    clr_exp++;
    chk("board_clr_count", clr_cnt, clr_exp);
    check_status();
  endtask

  initial begin
    int r, p, loc;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_upd_loc", upd_loc, 9);
    chk("rst_upd_val", upd_val, 0);
    chk("rst_board_clr", board_clr, 0);
    chk("rst_resp", {x_ack, x_nak, o_ack, o_nak}, 0);
    check_status();
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    clr_exp = 1;
    chk("board_clr_after_reset", clr_cnt, clr_exp);
    check_status();

    move(0, 4);
    move(1, 4);
    move(1, 12);
    move(0, 0);

    start_new_game();
    move(0, 0); move(1, 3); move(0, 1); move(1, 4); move(0, 2);
    move(1, 5);

    start_new_game();
    move(0, 0); move(1, 1); move(0, 2); move(1, 4); move(0, 3);
    move(1, 5); move(0, 7); move(1, 6); move(0, 8);

    start_new_game();
    move(0, 2); move(1, 0); move(0, 4); move(1, 1); move(0, 6);

    start_new_game();
    move(0, 1);
    start_new_game();
    abort_in_write(4);
    issue(1'b1, 4, 1'b1, 5);
    issue(1'b1, 0, 1'b1, 4);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4 || (m_over != 0 && r < 40)) begin
        start_new_game();
      end else if (r < 12) begin
        issue(1'b1, $urandom_range(0, 9), 1'b1, $urandom_range(0, 9));
      end else begin
        p   = ($urandom_range(0, 4) == 0) ? 1 - m_turn : m_turn;
        loc = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
        move(p, loc);
      end
    end

    repeat (4) @(posedge clock);
    #1;
    chk("pending_x_resp", qx.size(), 0);
    chk("pending_o_resp", qo.size(), 0);
    chk("pending_writes", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
